// File: rtl/crossbar_nxm_arb_pkg.sv
// Shared defaults and small index helpers for the LSU-to-bank-group crossbar.
package crossbar_nxm_arb_pkg;

  localparam int DEF_N_LSU  = 4;
  localparam int DEF_N_BG   = 4;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_LAT = 1;

  // (a + b) mod n, valid for a < n and b < n
  function automatic int wrap_add(int a, int b, int n);
    return (a + b >= n) ? (a + b - n) : (a + b);
  endfunction

  // v + 1 with wrap from n-1 back to 0
  function automatic int wrap_inc(int v, int n);
    return (v + 1 >= n) ? 0 : (v + 1);
  endfunction

endpackage

// File: rtl/crossbar_nxm_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i.
// The pointer register lives in the parent so this block stays stateless.
module rr_arbiter
  import crossbar_nxm_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           any_o
);

  int idx;

  // Scan from ptr_i upward (mod N); the first asserted request wins
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = wrap_add(int'(ptr_i), k, N);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/crossbar_nxm_arb.sv
// Registered N_LSU x N_BG crossbar with per-bank-group round-robin arbitration.
// Reads are tagged with their issuing LSU in a RD_LAT-deep ownership pipe so the
// bank-group read data can be steered back to the right LSU.
module crossbar_nxm_arb
  import crossbar_nxm_arb_pkg::*;
#(
  parameter  int N_LSU  = DEF_N_LSU,
  parameter  int N_BG   = DEF_N_BG,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int RD_LAT = DEF_RD_LAT,
  localparam int BG_W   = $clog2(N_BG),
  localparam int LID_W  = $clog2(N_LSU),
  localparam int AW     = BG_W + ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_LSU-1:0]                lsu_req_vld_i,
  input  logic [N_LSU-1:0]                lsu_req_we_i,
  input  logic [N_LSU-1:0][AW-1:0]        lsu_req_addr_i,
  input  logic [N_LSU-1:0][DATA_W-1:0]    lsu_req_wdata_i,
  output logic [N_LSU-1:0]                lsu_req_rdy_o,
  output logic [N_BG-1:0]                 bg_req_vld_o,
  output logic [N_BG-1:0]                 bg_req_we_o,
  output logic [N_BG-1:0][ADDR_W-1:0]     bg_addr_o,
  output logic [N_BG-1:0][DATA_W-1:0]     bg_wdata_o,
  input  logic [N_BG-1:0][DATA_W-1:0]     bg_rdata_i,
  output logic [N_LSU-1:0]                lsu_rsp_vld_o,
  output logic [N_LSU-1:0][DATA_W-1:0]    lsu_rsp_data_o
);

  // Arbitration
  logic [N_BG-1:0][N_LSU-1:0]   bg_req, bg_gnt;
  logic [N_BG-1:0][LID_W-1:0]   gnt_id;
  logic [N_BG-1:0]              gnt_any;
  logic [N_BG-1:0][LID_W-1:0]   ptr_q, ptr_d;

  // Issue stage
  logic [N_BG-1:0]              iss_vld_q, iss_vld_d;
  logic [N_BG-1:0]              iss_we_q, iss_we_d;
  logic [N_BG-1:0][ADDR_W-1:0]  iss_addr_q, iss_addr_d;
  logic [N_BG-1:0][DATA_W-1:0]  iss_wdata_q, iss_wdata_d;
  logic [N_BG-1:0][LID_W-1:0]   iss_id_q, iss_id_d;

  // Ownership pipes, stage RD_LAT-1 lines up with bg_rdata_i
  logic [N_BG-1:0][RD_LAT-1:0]            own_vld_q;
  logic [N_BG-1:0][RD_LAT-1:0][LID_W-1:0] own_id_q;

  // Response stage
  logic [N_LSU-1:0]             rsp_vld_q, rsp_vld_d;
  logic [N_LSU-1:0][DATA_W-1:0] rsp_data_q, rsp_data_d;

  // Decode: each valid LSU requests the bank group named by its upper address bits
  always_comb begin
    bg_req = '0;
    for (int b = 0; b < N_BG; b++) begin
      for (int i = 0; i < N_LSU; i++) begin
        bg_req[b][i] = lsu_req_vld_i[i] &&
                       (lsu_req_addr_i[i][AW-1 -: BG_W] == BG_W'(b));
      end
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < N_BG; gb++) begin : g_arb
      rr_arbiter #(.N(N_LSU)) u_arb (
        .req_i    (bg_req[gb]),
        .ptr_i    (ptr_q[gb]),
        .gnt_o    (bg_gnt[gb]),
        .gnt_id_o (gnt_id[gb]),
        .any_o    (gnt_any[gb])
      );
    end
  endgenerate

  // Ready: an LSU targets one bank group, so OR-ing all grant vectors is exact
  always_comb begin
    lsu_req_rdy_o = '0;
    for (int b = 0; b < N_BG; b++) lsu_req_rdy_o = lsu_req_rdy_o | bg_gnt[b];
  end

  // Pointer advance past the winner; idle bank groups keep their pointer.
  // Issue capture of the winning request; addr/wdata/id hold when idle.
  always_comb begin
    ptr_d       = ptr_q;
    iss_vld_d   = gnt_any;
    iss_we_d    = '0;
    iss_addr_d  = iss_addr_q;
    iss_wdata_d = iss_wdata_q;
    iss_id_d    = iss_id_q;
    for (int b = 0; b < N_BG; b++) begin
      if (gnt_any[b]) begin
        ptr_d[b]       = LID_W'(wrap_inc(int'(gnt_id[b]), N_LSU));
        iss_we_d[b]    = lsu_req_we_i[gnt_id[b]];
        iss_addr_d[b]  = lsu_req_addr_i[gnt_id[b]][ADDR_W-1:0];
        iss_wdata_d[b] = lsu_req_wdata_i[gnt_id[b]];
        iss_id_d[b]    = gnt_id[b];
      end
    end
  end

  // Arbiter pointers and issue registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      iss_vld_q   <= '0;
      iss_we_q    <= '0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      iss_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      iss_vld_q   <= iss_vld_d;
      iss_we_q    <= iss_we_d;
      iss_addr_q  <= iss_addr_d;
      iss_wdata_q <= iss_wdata_d;
      iss_id_q    <= iss_id_d;
    end
  end

  // Ownership shift pipes: only issued reads enter as valid, so writes never respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_vld_q <= '0;
      own_id_q  <= '0;
    end else begin
      for (int b = 0; b < N_BG; b++) begin
        own_vld_q[b][0] <= iss_vld_q[b] & ~iss_we_q[b];
        own_id_q[b][0]  <= iss_id_q[b];
        for (int s = 1; s < RD_LAT; s++) begin
          own_vld_q[b][s] <= own_vld_q[b][s-1];
          own_id_q[b][s]  <= own_id_q[b][s-1];
        end
      end
    end
  end

  // Response steering: fixed latency keeps at most one bank group per LSU per cycle
  always_comb begin
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    for (int b = 0; b < N_BG; b++) begin
      if (own_vld_q[b][RD_LAT-1]) begin
        rsp_vld_d[own_id_q[b][RD_LAT-1]]  = 1'b1;
        rsp_data_d[own_id_q[b][RD_LAT-1]] = bg_rdata_i[b];
      end
    end
  end

  // Response registers; data holds while no response is pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bg_req_vld_o   = iss_vld_q;
  assign bg_req_we_o    = iss_we_q;
  assign bg_addr_o      = iss_addr_q;
  assign bg_wdata_o     = iss_wdata_q;
  assign lsu_rsp_vld_o  = rsp_vld_q;
  assign lsu_rsp_data_o = rsp_data_q;

endmodule

// File: tb/tb_crossbar_nxm_arb.sv
// Bench for crossbar_nxm_arb: three configurations (4x4 RD_LAT=1, 8x2 RD_LAT=2,
// 4x4 RD_LAT=3) sharing clock and reset. Expected read responses are queued
// per LSU with their due cycle; a negedge monitor pops and compares.
module tb_crossbar_nxm_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int c_bad = 0;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t qa[4][$];
  exp_t qb[8][$];

  function automatic logic [31:0] bdat(int g, logic [9:0] a);
    return 32'hC0DE_0000 ^ (32'(g) << 20) ^ {22'd0, a};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // ---------------- instance A: 4 LSU, 4 BG, RD_LAT=1
  logic [3:0]        a_vld, a_we, a_rdy, a_bvld, a_bwe, a_rvld;
  logic [3:0][11:0]  a_addr;
  logic [3:0][31:0]  a_wdata, a_bwdata, a_brdata, a_rdata;
  logic [3:0][9:0]   a_baddr, a_pipe;

  crossbar_nxm_arb #(.N_LSU(4), .N_BG(4), .ADDR_W(10), .DATA_W(32), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .lsu_req_vld_i(a_vld), .lsu_req_we_i(a_we), .lsu_req_addr_i(a_addr),
    .lsu_req_wdata_i(a_wdata), .lsu_req_rdy_o(a_rdy),
    .bg_req_vld_o(a_bvld), .bg_req_we_o(a_bwe), .bg_addr_o(a_baddr),
    .bg_wdata_o(a_bwdata), .bg_rdata_i(a_brdata),
    .lsu_rsp_vld_o(a_rvld), .lsu_rsp_data_o(a_rdata)
  );

  always @(posedge clk) a_pipe <= a_baddr;
  always_comb begin
    a_brdata = '0;
    for (int g = 0; g < 4; g++) a_brdata[g] = bdat(g, a_pipe[g]);
  end

  // ---------------- instance B: 8 LSU, 2 BG, RD_LAT=2
  logic [7:0]        b_vld, b_we, b_rdy, b_rvld, b_acc;
  logic [7:0][10:0]  b_addr;
  logic [7:0][31:0]  b_wdata, b_rdata;
  logic [1:0]        b_bvld, b_bwe;
  logic [1:0][9:0]   b_baddr, b_p0, b_p1;
  logic [1:0][31:0]  b_bwdata, b_brdata;

  crossbar_nxm_arb #(.N_LSU(8), .N_BG(2), .ADDR_W(10), .DATA_W(32), .RD_LAT(2)) u_b (
    .clk(clk), .rst(rst),
    .lsu_req_vld_i(b_vld), .lsu_req_we_i(b_we), .lsu_req_addr_i(b_addr),
    .lsu_req_wdata_i(b_wdata), .lsu_req_rdy_o(b_rdy),
    .bg_req_vld_o(b_bvld), .bg_req_we_o(b_bwe), .bg_addr_o(b_baddr),
    .bg_wdata_o(b_bwdata), .bg_rdata_i(b_brdata),
    .lsu_rsp_vld_o(b_rvld), .lsu_rsp_data_o(b_rdata)
  );

  always @(posedge clk) begin
    b_p0 <= b_baddr;
    b_p1 <= b_p0;
  end
  always_comb begin
    b_brdata = '0;
    for (int g = 0; g < 2; g++) b_brdata[g] = bdat(g, b_p1[g]);
  end

  // ---------------- instance C: 4 LSU, 4 BG, RD_LAT=3 (reset test)
  logic [3:0]        c_vld, c_we, c_rdy, c_bvld, c_bwe, c_rvld;
  logic [3:0][11:0]  c_addr;
  logic [3:0][31:0]  c_wdata, c_bwdata, c_brdata, c_rdata;
  logic [3:0][9:0]   c_baddr;

  assign c_brdata = {4{32'h1234_5678}};

  crossbar_nxm_arb #(.N_LSU(4), .N_BG(4), .ADDR_W(10), .DATA_W(32), .RD_LAT(3)) u_c (
    .clk(clk), .rst(rst),
    .lsu_req_vld_i(c_vld), .lsu_req_we_i(c_we), .lsu_req_addr_i(c_addr),
    .lsu_req_wdata_i(c_wdata), .lsu_req_rdy_o(c_rdy),
    .bg_req_vld_o(c_bvld), .bg_req_we_o(c_bwe), .bg_addr_o(c_baddr),
    .bg_wdata_o(c_bwdata), .bg_rdata_i(c_brdata),
    .lsu_rsp_vld_o(c_rvld), .lsu_rsp_data_o(c_rdata)
  );

  // ---------------- response monitor
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a_rvld[i] === 1'b1) begin
        exp_t e;
        if (qa[i].size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL a_rsp_unexpected lsu%0d: got data %0h at cycle %0d, required no response",
                   i, a_rdata[i], cyc);
        end else begin
          e = qa[i].pop_front();
          chk($sformatf("a_rsp_data lsu%0d", i), 64'(a_rdata[i]), 64'(e.d));
          chk($sformatf("a_rsp_cycle lsu%0d", i), 64'(cyc), 64'(e.c));
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (b_rvld[i] === 1'b1) begin
        exp_t e;
        if (qb[i].size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_rsp_unexpected lsu%0d: got data %0h at cycle %0d, required no response",
                   i, b_rdata[i], cyc);
        end else begin
          e = qb[i].pop_front();
          chk($sformatf("b_rsp_data lsu%0d", i), 64'(b_rdata[i]), 64'(e.d));
          chk($sformatf("b_rsp_cycle lsu%0d", i), 64'(cyc), 64'(e.c));
        end
      end
    end
    if (c_rvld !== 4'b0000) c_bad++;
  end

  task automatic pa(int i, logic [31:0] d, int c);
    exp_t e;
    e.d = d; e.c = c;
    qa[i].push_back(e);
  endtask

  task automatic pb(int i, logic [31:0] d, int c);
    exp_t e;
    e.d = d; e.c = c;
    qb[i].push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random stimulus
  initial begin
    int ptrm[2];
    int wt[8];
    int maxw;
    int leftover;
    logic [7:0] erdy;

    a_vld = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_vld = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_acc = '0;
    c_vld = '0; c_we = '0; c_addr = '0; c_wdata = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    chk("rst a_bvld", 64'(a_bvld), 64'h0);
    chk("rst a_rvld", 64'(a_rvld), 64'h0);
    chk("rst a_baddr", 64'(a_baddr), 64'h0);
    chk("rst a_bwdata3", 64'(a_bwdata[3]), 64'h0);
    chk("rst a_rdata2", 64'(a_rdata[2]), 64'h0);
    chk("rst b_bvld", 64'(b_bvld), 64'h0);
    chk("rst b_rvld", 64'(b_rvld), 64'h0);
    chk("rst c_bvld", 64'(c_bvld), 64'h0);
    step();
    rst = 1'b0;
    step();

    // 1: one read per LSU to its own bank group
    for (int i = 0; i < 4; i++) begin
      a_vld[i] = 1'b1;
      a_addr[i] = {2'(i), 10'(16 + i)};
    end
    smp();
    chk("t1 rdy", 64'(a_rdy), 64'hF);
    for (int i = 0; i < 4; i++) pa(i, bdat(i, 10'(16 + i)), cyc + 3);
    step();
    a_vld = '0;
    smp();
    chk("t1 bvld", 64'(a_bvld), 64'hF);
    for (int i = 0; i < 4; i++) chk($sformatf("t1 baddr%0d", i), 64'(a_baddr[i]), 64'(16 + i));
    repeat (4) step();

    // 2: all four LSUs read BG2 from reset; grants 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_vld[i] = 1'b1;
      a_addr[i] = {2'd2, 10'(32 + i)};
    end
    for (int k = 0; k < 4; k++) begin
      smp();
      chk($sformatf("t2 rdy k%0d", k), 64'(a_rdy), 64'(4'b0001 << k));
      if (k > 0) chk($sformatf("t2 bvld k%0d", k), 64'(a_bvld), 64'h4);
      pa(k, bdat(2, 10'(32 + k)), cyc + 3);
      step();
      a_vld[k] = 1'b0;
    end
    smp();
    chk("t2 bvld last", 64'(a_bvld), 64'h4);
    chk("t2 baddr last", 64'(a_baddr[2]), 64'd35);
    step();
    smp();
    chk("t2 bvld idle", 64'(a_bvld), 64'h0);
    chk("t2 baddr hold", 64'(a_baddr[2]), 64'd35);
    repeat (4) step();

    // 3: LSU1 and LSU3 hammer BG0 with ptr=0 -> 1,3,1,3,...
    a_vld = 4'b1010;
    a_addr[1] = {2'd0, 10'h101};
    a_addr[3] = {2'd0, 10'h303};
    for (int k = 0; k < 6; k++) begin
      smp();
      chk($sformatf("t3 rdy k%0d", k), 64'(a_rdy), (k % 2 == 0) ? 64'h2 : 64'h8);
      if (k % 2 == 0) pa(1, bdat(0, 10'h101), cyc + 3);
      else            pa(3, bdat(0, 10'h303), cyc + 3);
      step();
    end
    a_vld = '0;
    repeat (5) step();

    // 4: write from LSU2 to BG1, no response expected
    a_vld[2] = 1'b1;
    a_we[2] = 1'b1;
    a_addr[2] = {2'd1, 10'h005};
    a_wdata[2] = 32'hDEAD_BEEF;
    smp();
    chk("t4 rdy", 64'(a_rdy), 64'h4);
    step();
    a_vld = '0;
    a_we = '0;
    smp();
    chk("t4 bvld", 64'(a_bvld), 64'h2);
    chk("t4 bwe", 64'(a_bwe), 64'h2);
    chk("t4 baddr", 64'(a_baddr[1]), 64'h5);
    chk("t4 bwdata", 64'(a_bwdata[1]), 64'hDEAD_BEEF);
    step();
    smp();
    chk("t4 bvld idle", 64'(a_bvld), 64'h0);
    chk("t4 baddr hold", 64'(a_baddr[1]), 64'h5);
    chk("t4 bwdata hold", 64'(a_bwdata[1]), 64'hDEAD_BEEF);
    repeat (3) step();
    smp();
    chk("rsp idle", 64'(a_rvld), 64'h0);
    chk("rsp data hold", 64'(a_rdata[3]), 64'(bdat(0, 10'h303)));
    step();

    // 5: reset one cycle after a read is accepted (RD_LAT=3)
    do_reset();
    c_vld[0] = 1'b1;
    c_addr[0] = {2'd0, 10'h011};
    smp();
    chk("t5 rdy", 64'(c_rdy), 64'h1);
    step();
    c_vld = '0;
    smp();
    chk("t5 bvld issued", 64'(c_bvld), 64'h1);
    rst = 1'b1;
    #1;
    chk("t5 bvld in reset", 64'(c_bvld), 64'h0);
    chk("t5 rvld in reset", 64'(c_rvld), 64'h0);
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("t5 no response", 64'(c_bad), 64'h0);
    c_vld = 4'b0011;
    c_we = 4'b0011;
    c_addr[0] = {2'd0, 10'h001};
    c_addr[1] = {2'd0, 10'h002};
    smp();
    chk("t5 ptr after reset", 64'(c_rdy), 64'h1);
    step();
    c_vld = '0;
    c_we = '0;
    repeat (3) step();

    // 6: random traffic, 8 LSU / 2 BG, reference RR model and read scoreboard
    ptrm = '{0, 0};
    wt = '{default: 0};
    maxw = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (!(b_vld[i] && !b_acc[i])) begin
          b_vld[i]   = (n < 9980) && ($urandom_range(0, 9) < 6);
          b_we[i]    = ($urandom_range(0, 3) == 0);
          b_addr[i]  = 11'($urandom);
          b_wdata[i] = $urandom;
        end
      end
      smp();
      erdy = '0;
      for (int g = 0; g < 2; g++) begin
        int win;
        win = -1;
        for (int k = 0; k < 8; k++) begin
          int j;
          j = (ptrm[g] + k) % 8;
          if (win < 0 && b_vld[j] && int'(b_addr[j][10]) == g) win = j;
        end
        if (win >= 0) begin
          erdy[win] = 1'b1;
          ptrm[g] = (win + 1) % 8;
        end
      end
      chk("t6 rdy", 64'(b_rdy), 64'(erdy));
      for (int i = 0; i < 8; i++) begin
        if (b_vld[i]) begin
          if (erdy[i]) begin
            if (wt[i] + 1 > maxw) maxw = wt[i] + 1;
            wt[i] = 0;
            if (!b_we[i]) pb(i, bdat(int'(b_addr[i][10]), b_addr[i][9:0]), cyc + 4);
          end else begin
            wt[i]++;
          end
        end
      end
      b_acc = b_vld & b_rdy;
      step();
    end
    b_vld = '0;
    repeat (10) step();
    n_cmp++;
    if (maxw > 8) begin
      n_err++;
      $display("FAIL t6 grant wait: got %0d cycles, required <= 8", maxw);
    end

    leftover = 0;
    for (int i = 0; i < 4; i++) leftover += qa[i].size();
    for (int i = 0; i < 8; i++) leftover += qb[i].size();
    chk("queues drained", 64'(leftover), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
